// File: rtl/prefetch_queue_arm.sv
// ARM instruction prefetch stage: single-outstanding instruction-bus fetcher feeding
// a small {code, pc} FIFO that the decoder drains over valid/ready.
module prefetch_queue_arm #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic [31:0] flush_pc,
    output logic        ibus_req,
    output logic [31:0] ibus_addr,
    input  logic        ibus_ack,
    input  logic [31:0] ibus_rdata,
    output logic        out_valid,
    output logic [31:0] out_code,
    output logic [31:0] out_pc,
    input  logic        out_ready
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DROP  = 2'd2
    } state_t;

    state_t        state_reg;
    logic [31:0]   fetch_pc_reg;
    logic [31:0]   ibus_addr_reg;
    logic          ibus_req_reg;
    logic          out_valid_reg;
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [CW-1:0] count_reg;
    logic [CW-1:0] count_next;

    logic          push;
    logic          pop;
    logic          has_space;
    logic [31:0]   flush_target;
    logic [31:0]   fetch_pc_inc;

    logic [31:0]   code_word [DEPTH];
    logic [31:0]   pc_word   [DEPTH];

    assign flush_target = {flush_pc[31:2], 2'b00};
    assign fetch_pc_inc = fetch_pc_reg + 32'd4;

    // A flush cancels both the push of a concurrent ack and the pop of a concurrent accept.
    assign push = (state_reg == FETCH) && ibus_req_reg && ibus_ack && !flush;
    assign pop  = out_valid_reg && out_ready && !flush;

    always_comb begin
        count_next = count_reg;
        if (flush) begin
            count_next = '0;
        end else if (push && !pop) begin
            count_next = count_reg + CW'(1);
        end else if (pop && !push) begin
            count_next = count_reg - CW'(1);
        end
    end

    assign has_space = (count_next < FULL_COUNT);

    // Queue storage: one register pair per entry, cleared by reset so the
    // head reads as zero until the first word lands.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [31:0] code_reg;
            logic [31:0] pc_reg;

            always_ff @(posedge clk) begin
                if (rst) begin
                    code_reg <= '0;
                    pc_reg   <= '0;
                end else if (push && (wr_ptr_reg == AW'(gi))) begin
                    code_reg <= ibus_rdata;
                    pc_reg   <= fetch_pc_reg;
                end
            end

            assign code_word[gi] = code_reg;
            assign pc_word[gi]   = pc_reg;
        end
    endgenerate

    // Control FSM, queue pointers and registered bus outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            ibus_req_reg  <= 1'b0;
            ibus_addr_reg <= RESET_PC;
            fetch_pc_reg  <= RESET_PC;
            count_reg     <= '0;
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            out_valid_reg <= 1'b0;
        end else begin
            count_reg     <= count_next;
            out_valid_reg <= (count_next != '0);

            if (flush) begin
                wr_ptr_reg   <= '0;
                rd_ptr_reg   <= '0;
                fetch_pc_reg <= flush_target;
            end else begin
                if (push) begin
                    wr_ptr_reg   <= wr_ptr_reg + AW'(1);
                    fetch_pc_reg <= fetch_pc_inc;
                end
                if (pop) begin
                    rd_ptr_reg <= rd_ptr_reg + AW'(1);
                end
            end

            unique case (state_reg)
                IDLE: begin
                    if (has_space) begin
                        state_reg     <= FETCH;
                        ibus_req_reg  <= 1'b1;
                        ibus_addr_reg <= flush ? flush_target : fetch_pc_reg;
                    end
                end

                FETCH: begin
                    if (flush) begin
                        ibus_req_reg <= 1'b1;
                        if (ibus_ack) begin
                            state_reg     <= FETCH;
                            ibus_addr_reg <= flush_target;
                        end else begin
                            // The open request cannot be withdrawn: keep presenting
                            // the old address and swallow its data later.
                            state_reg <= DROP;
                        end
                    end else if (ibus_ack) begin
                        ibus_addr_reg <= fetch_pc_inc;
                        if (has_space) begin
                            state_reg    <= FETCH;
                            ibus_req_reg <= 1'b1;
                        end else begin
                            state_reg    <= IDLE;
                            ibus_req_reg <= 1'b0;
                        end
                    end
                end

                DROP: begin
                    ibus_req_reg <= 1'b1;
                    if (ibus_ack) begin
                        state_reg     <= FETCH;
                        ibus_addr_reg <= flush ? flush_target : fetch_pc_reg;
                    end
                end

                default: begin
                    state_reg    <= IDLE;
                    ibus_req_reg <= 1'b0;
                end
            endcase
        end
    end

    assign ibus_req  = ibus_req_reg;
    assign ibus_addr = ibus_addr_reg;
    assign out_valid = out_valid_reg;
    assign out_code  = code_word[rd_ptr_reg];
    assign out_pc    = pc_word[rd_ptr_reg];

endmodule

// File: tb/tb_prefetch_queue_arm.sv
// Bench for prefetch_queue_arm: directed vector table, hand-written flush/wrap/reset
// sequences, then random traffic against a queue-based reference model.
module tb_prefetch_queue_arm;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0100;

    logic        clk;
    logic        rst;
    logic        flush;
    logic [31:0] flush_pc;
    logic        ibus_req;
    logic [31:0] ibus_addr;
    logic        ibus_ack;
    logic [31:0] ibus_rdata;
    logic        out_valid;
    logic [31:0] out_code;
    logic [31:0] out_pc;
    logic        out_ready;

    prefetch_queue_arm #(
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .flush_pc   (flush_pc),
        .ibus_req   (ibus_req),
        .ibus_addr  (ibus_addr),
        .ibus_ack   (ibus_ack),
        .ibus_rdata (ibus_rdata),
        .out_valid  (out_valid),
        .out_code   (out_code),
        .out_pc     (out_pc),
        .out_ready  (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: fetch queue, fetch pointer, outstanding-request flags.
    logic [63:0] mq[$];
    logic [31:0] m_fpc  = RESET_PC;
    logic [31:0] m_addr = RESET_PC;
    bit          m_req  = 1'b0;
    bit          m_drop = 1'b0;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=%h required=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit ack_done;
        if (rst) begin
            mq.delete();
            m_req  = 1'b0;
            m_drop = 1'b0;
            m_fpc  = RESET_PC;
            m_addr = RESET_PC;
            return;
        end
        ack_done = m_req && ibus_ack;
        if (flush) begin
            mq.delete();
            m_fpc = {flush_pc[31:2], 2'b00};
            if (!m_req) begin
                m_req  = 1'b1;
                m_addr = m_fpc;
            end else if (m_drop) begin
                if (ack_done) begin
                    m_drop = 1'b0;
                    m_addr = m_fpc;
                end
            end else if (ack_done) begin
                m_addr = m_fpc;
            end else begin
                m_drop = 1'b1;
            end
        end else begin
            if (mq.size() != 0 && out_ready) void'(mq.pop_front());
            if (m_drop) begin
                if (ack_done) begin
                    m_drop = 1'b0;
                    m_addr = m_fpc;
                end
            end else if (!m_req) begin
                if (mq.size() < DEPTH) begin
                    m_req  = 1'b1;
                    m_addr = m_fpc;
                end
            end else if (ack_done) begin
                mq.push_back({ibus_rdata, m_fpc});
                m_fpc = m_fpc + 32'd4;
                if (mq.size() < DEPTH) m_addr = m_fpc;
                else m_req = 1'b0;
            end
        end
    endtask

    task automatic check_model();
        logic [63:0] head;
        chk("req", 32'(ibus_req), 32'(m_req));
        if (m_req) chk("addr", ibus_addr, m_addr);
        chk("valid", 32'(out_valid), 32'(mq.size() != 0));
        if (mq.size() != 0) begin
            head = mq[0];
            chk("code", out_code, head[63:32]);
            chk("pc", out_pc, head[31:0]);
        end
    endtask

    // One clock cycle: drive inputs, clock edge, advance model, compare on falling edge.
    task automatic step(input bit r, input bit f, input logic [31:0] fp,
                        input bit a, input bit rdy);
        rst        = r;
        flush      = f;
        flush_pc   = fp;
        ibus_ack   = a;
        out_ready  = rdy;
        ibus_rdata = m_req ? mem(m_addr) : $urandom;
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_model();
    endtask

    typedef struct {
        bit          rst;
        bit          ack;
        bit          ready;
        bit          exp_req;
        logic [31:0] exp_addr;
        bit          exp_valid;
        logic [31:0] exp_pc;
    } vec_t;

    function automatic vec_t mk(bit r, bit a, bit rdy, bit er, logic [31:0] ea,
                                bit ev, logic [31:0] ep);
        vec_t v;
        v.rst = r; v.ack = a; v.ready = rdy;
        v.exp_req = er; v.exp_addr = ea; v.exp_valid = ev; v.exp_pc = ep;
        return v;
    endfunction

    vec_t tbl[15];

    initial begin
        rst = 1'b1; flush = 1'b0; flush_pc = '0;
        ibus_ack = 1'b0; ibus_rdata = '0; out_ready = 1'b0;

        // Streaming, then fill-to-full with the decoder stalled, then drain.
        tbl[0]  = mk(1, 1, 1, 0, 32'h100, 0, 32'h0);
        tbl[1]  = mk(0, 1, 1, 1, 32'h100, 0, 32'h0);
        tbl[2]  = mk(0, 1, 1, 1, 32'h104, 1, 32'h100);
        tbl[3]  = mk(0, 1, 1, 1, 32'h108, 1, 32'h104);
        tbl[4]  = mk(0, 1, 1, 1, 32'h10C, 1, 32'h108);
        tbl[5]  = mk(0, 0, 1, 1, 32'h10C, 0, 32'h0);
        tbl[6]  = mk(0, 1, 0, 1, 32'h110, 1, 32'h10C);
        tbl[7]  = mk(0, 1, 0, 1, 32'h114, 1, 32'h10C);
        tbl[8]  = mk(0, 1, 0, 1, 32'h118, 1, 32'h10C);
        tbl[9]  = mk(0, 1, 0, 0, 32'h0,   1, 32'h10C);
        tbl[10] = mk(0, 1, 0, 0, 32'h0,   1, 32'h10C);
        tbl[11] = mk(0, 0, 1, 1, 32'h11C, 1, 32'h110);
        tbl[12] = mk(0, 0, 1, 1, 32'h11C, 1, 32'h114);
        tbl[13] = mk(0, 0, 1, 1, 32'h11C, 1, 32'h118);
        tbl[14] = mk(0, 0, 1, 1, 32'h11C, 0, 32'h0);

        for (int i = 0; i < 15; i++) begin
            step(tbl[i].rst, 1'b0, 32'h0, tbl[i].ack, tbl[i].ready);
            chk("tbl_req", 32'(ibus_req), 32'(tbl[i].exp_req));
            if (tbl[i].exp_req || tbl[i].rst) chk("tbl_addr", ibus_addr, tbl[i].exp_addr);
            chk("tbl_valid", 32'(out_valid), 32'(tbl[i].exp_valid));
            if (tbl[i].exp_valid) begin
                chk("tbl_pc", out_pc, tbl[i].exp_pc);
                chk("tbl_code", out_code, mem(tbl[i].exp_pc));
            end
            $display("vec %0d: req=%0b addr=%h valid=%0b pc=%h", i, ibus_req, ibus_addr,
                     out_valid, out_pc);
        end

        // Flush while a request is open and the ack arrives three cycles later.
        step(0, 1, 32'h0000_2003, 0, 1);
        chk("drop_req", 32'(ibus_req), 32'h1);
        chk("drop_hold0", ibus_addr, 32'h11C);
        step(0, 0, 32'h0, 0, 1);
        chk("drop_hold1", ibus_addr, 32'h11C);
        step(0, 0, 32'h0, 0, 1);
        chk("drop_hold2", ibus_addr, 32'h11C);
        step(0, 0, 32'h0, 1, 1);
        chk("drop_newaddr", ibus_addr, 32'h2000);
        chk("drop_noout", 32'(out_valid), 32'h0);
        step(0, 0, 32'h0, 1, 1);
        chk("drop_firstpc", out_pc, 32'h2000);
        $display("seq drop: addr=%h out_pc=%h", ibus_addr, out_pc);

        // Flush coinciding with ack and pop at count=2.
        step(0, 0, 32'h0, 1, 0);
        step(0, 1, 32'h0000_3000, 1, 1);
        chk("fap_valid", 32'(out_valid), 32'h0);
        chk("fap_req", 32'(ibus_req), 32'h1);
        chk("fap_addr", ibus_addr, 32'h3000);
        $display("seq flush+ack+pop: valid=%0b addr=%h", out_valid, ibus_addr);

        // Fetch address wrap at the top of the address space.
        step(0, 1, 32'hFFFF_FFFC, 1, 0);
        chk("wrap_addr0", ibus_addr, 32'hFFFF_FFFC);
        step(0, 0, 32'h0, 1, 0);
        chk("wrap_pc", out_pc, 32'hFFFF_FFFC);
        chk("wrap_addr1", ibus_addr, 32'h0);
        $display("seq wrap: out_pc=%h next_addr=%h", out_pc, ibus_addr);

        // Reset with three entries queued and a transfer in flight.
        step(0, 0, 32'h0, 1, 0);
        step(0, 0, 32'h0, 1, 0);
        step(0, 0, 32'h0, 0, 0);
        step(1, 0, 32'h0, 1, 1);
        chk("rst_valid", 32'(out_valid), 32'h0);
        chk("rst_req", 32'(ibus_req), 32'h0);
        chk("rst_addr", ibus_addr, RESET_PC);
        chk("rst_code", out_code, 32'h0);
        chk("rst_pc", out_pc, 32'h0);
        step(0, 0, 32'h0, 0, 1);
        chk("rst_restart_req", 32'(ibus_req), 32'h1);
        chk("rst_restart_addr", ibus_addr, RESET_PC);
        $display("seq reset: req=%0b addr=%h", ibus_req, ibus_addr);

        // Random traffic: first half biased towards a stalled decoder.
        for (int i = 0; i < 3000; i++) begin
            bit r;
            bit f;
            bit a;
            bit rdy;
            r   = ($urandom_range(0, 999) < 4);
            f   = ($urandom_range(0, 99) < 4);
            a   = ($urandom_range(0, 2) != 0);
            rdy = (i < 1500) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            step(r, f, $urandom, a, rdy);
        end
        $display("random phase done");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/prefetch_queue_arm.md
# prefetch_queue_arm

Instruction prefetch stage that sits directly upstream of the ARM instruction decoder. It fetches 32-bit ARM words from the instruction bus using a single-outstanding req/ack handshake and buffers them in a small FIFO. It presents each word with its address to the decode stage over a valid/ready interface. On a pipeline flush (branch, exception, PC write) it discards all queued and in-flight words and restarts fetching at the new PC.

## Interface
- DEPTH, 4, queue entries; power of 2, minimum 2
- RESET_PC, 32'h0000_0000, first fetch address after reset
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous reset, active-high
- flush  in  1  discard the queue and any in-flight fetch, redirect to flush_pc
- flush_pc  in  32  new fetch address; bits [1:0] ignored and forced to 0
- ibus_req  out  1  fetch request
- ibus_addr  out  32  word-aligned fetch address; stable while ibus_req=1
- ibus_ack  in  1  transfer completes in the cycle where ibus_req=1 and ibus_ack=1
- ibus_rdata  in  32  instruction word; valid only in the ack cycle
- out_valid  out  1  head entry valid
- out_code  out  32  head instruction word, driven to the decoder code input
- out_pc  out  32  address of out_code
- out_ready  in  1  decoder accepts the head entry this cycle

## Operation
- Storage: DEPTH-entry circular FIFO of {code, pc}, with write pointer, read pointer and count (log2(DEPTH)+1 bits). out_valid = (count != 0). out_code/out_pc are read from the head entry.
- Pop: out_valid & out_ready & ~flush advances the read pointer.
- Push: ibus_req & ibus_ack in state FETCH, with ~flush, writes {ibus_rdata, fetch_pc} and sets fetch_pc += 4. fetch_pc wraps modulo 2^32 (32'hFFFF_FFFC → 0).
- Only one request is outstanding at a time. A request is started only when count < DEPTH, so an ack always finds space. Push and pop in the same cycle leave count unchanged.
- FSM states: IDLE, FETCH, DROP.
  - IDLE: ibus_req=0. If count_next < DEPTH, go to FETCH.
  - FETCH: ibus_req=1, ibus_addr=fetch_pc.
    - On ack without flush: push; stay in FETCH if count_next < DEPTH, otherwise go to IDLE.
    - On flush with no ack: go to DROP.
    - On flush with ack: the data is discarded; go to FETCH at flush_pc.
  - DROP: ibus_req stays 1 and ibus_addr holds the old address, because a request may not be withdrawn. On ack the data is discarded and the state goes to FETCH. A further flush in DROP updates fetch_pc only.
- Flush, in any state: count, read pointer and write pointer go to 0, and fetch_pc is set to {flush_pc[31:2],2'b00}. A pop in the flush cycle is ignored. out_valid is 0 in the following cycle.
- Reset: state IDLE, ibus_req=0, ibus_addr=RESET_PC, fetch_pc=RESET_PC, count=0, out_valid=0, out_code=0, out_pc=0 (storage cleared). Any bus transfer in flight is abandoned. rst has priority over flush.
- In DROP, ibus_addr is a separate held register, distinct from fetch_pc.

## Timing
- Cycle 0 is the first cycle with rst=0. ibus_req=1 with ibus_addr=RESET_PC in cycle 1, registered from the IDLE→FETCH transition.
- Zero-wait bus (ack in the same cycle as req): the word is pushed in cycle N and out_valid=1 in cycle N+1. Back-to-back acks sustain 1 word/cycle.
- Flush in cycle N: out_valid=0 in N+1. ibus_req=1 with ibus_addr=flush_pc in N+1, unless the state is DROP.
- With the queue full and out_ready=1: the pop in cycle N frees space, and ibus_req rises in N+1.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Test plan
- Reset, RESET_PC=0x100, ack tied 1, out_ready=1: ibus_addr 0x100, 0x104, 0x108…; out_pc follows one cycle later; out_code equals the memory model contents.
- out_ready=0, ack=1: exactly DEPTH(4) pushes, ibus_req drops to 0, and count holds at 4. Raise out_ready: 4 pops occur in order and req restarts one cycle after the first pop.
- Flush to 0x2003 while req is pending and ack is delayed 3 cycles: the state enters DROP, the old address is held until ack, the returned word is never output, and the next ibus_addr is 0x2000.
- Flush in the same cycle as ack and pop with the queue at count=2: no push, out_valid=0 next cycle, next ibus_addr=flush_pc.
- fetch_pc=0xFFFFFFFC: the ack yields an entry with out_pc 0xFFFFFFFC, and the next ibus_addr=0x0.
- Assert rst mid-transfer with 3 entries queued: the next cycle has out_valid=0, ibus_req=0 and ibus_addr=RESET_PC. Fetching restarts as after a power-on reset.
